// File: rtl/alu4_pkg.sv
// alu4_pkg: shared ALU function codes, result type and evaluation function
package alu4_pkg;
    typedef enum logic [1:0] {ADD, SUB, AND, OR} alu_func_e;
    typedef struct packed {
        logic [3:0] d;
        logic       co;
    } alu_res_t;
    function automatic alu_res_t alu4_eval(input logic [3:0] a, input logic [3:0] b, input alu_func_e f, input logic cci);
        logic [4:0] w_s;
        w_s = f == ADD ? {1'b0, a} + {1'b0, b} + {4'b0, cci} : {1'b0, a} - {1'b0, b} - {4'b0, cci};
        return f == AND ? {a & b, 1'b0} : f == OR ? {a | b, 1'b0} : {w_s[3:0], w_s[4]};
    endfunction
endpackage

// File: rtl/alu4_op_responder_if.sv
// alu4_op_responder_if: request and response valid/ready channels plus completion count
interface alu4_op_responder_if #(parameter int CNT_W = 16);
    logic             req_valid, req_ready, req_cci, resp_valid, resp_ready, resp_co;
    logic [3:0]       req_a, req_b, resp_d;
    logic [1:0]       req_f;
    logic [CNT_W-1:0] ops_done;
    modport master (
        output req_valid, req_a, req_b, req_f, req_cci, resp_ready,
        input  req_ready, resp_valid, resp_d, resp_co, ops_done
    );
    modport slave (
        input  req_valid, req_a, req_b, req_f, req_cci, resp_ready,
        output req_ready, resp_valid, resp_d, resp_co, ops_done
    );
endinterface

// File: rtl/alu4_res_fifo.sv
// alu4_res_fifo: synchronous result FIFO, occupancy counter separates full from empty
module alu4_res_fifo import alu4_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  logic     i_pop,
    input  alu_res_t i_data,
    output logic     o_full,
    output logic     o_empty,
    output alu_res_t o_head
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    alu_res_t      r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_head  = r_mem[r_rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp == PW'(DEPTH - 1) ? '0 : r_wp + PW'(1);
            if (i_pop) r_rp <= r_rp == PW'(DEPTH - 1) ? '0 : r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/alu4_op_responder.sv
// alu4_op_responder: valid/ready ALU front end with a stage-1 register feeding an in-order result FIFO
module alu4_op_responder import alu4_pkg::*; #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    alu4_op_responder_if.slave bus
);
    typedef enum logic {S1_EMPTY, S1_FULL} s1_state_e;
    s1_state_e        r_state, w_next;
    alu_res_t         r_s1, w_head;
    logic             w_full, w_empty, w_acc, w_move, w_pop;
    logic [CNT_W-1:0] r_ops_done;
    // in-flight reaches FIFO_DEPTH+1 exactly when stage 1 and the FIFO are both full
    assign bus.req_ready  = !(r_state == S1_FULL && w_full);
    assign w_acc          = bus.req_valid && bus.req_ready;
    assign w_pop          = !w_empty && bus.resp_ready;
    assign w_move         = r_state == S1_FULL && (!w_full || w_pop);
    assign bus.resp_valid = !w_empty;
    assign bus.resp_d     = w_empty ? 4'h0 : w_head.d;
    assign bus.resp_co    = !w_empty && w_head.co;
    assign bus.ops_done   = r_ops_done;
    always_comb begin
        w_next = w_acc ? S1_FULL : w_move ? S1_EMPTY : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S1_EMPTY;
            r_ops_done <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_ops_done <= r_ops_done + CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (w_acc) r_s1 <= alu4_eval(bus.req_a, bus.req_b, alu_func_e'(bus.req_f), bus.req_cci);
    end
    alu4_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_move),
        .i_pop   (w_pop),
        .i_data  (r_s1),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );
endmodule

// File: tb/tb_alu4_op_responder.sv
// tb_alu4_op_responder: randomized scoreboard bench against an arithmetic reference model
module tb_alu4_op_responder;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 4;
    typedef struct {
        logic [3:0] d;
        logic       co;
        int         e;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    int   n_acc = 0;
    int   n_resp = 0;
    int   m_done = 0;
    logic done = 1'b0;
    exp_t q[$];
    alu4_op_responder_if #(.CNT_W(CNT_W)) bus();
    alu4_op_responder #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) edges++;
    function automatic exp_t ref_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f, input logic c, input int e);
        exp_t r;
        int   s;
        s = f == 2'd0 ? int'(a) + int'(b) + int'(c) : f == 2'd1 ? int'(a) - int'(b) - int'(c) : f == 2'd2 ? int'(a & b) : int'(a | b);
        r.d  = 4'(s);
        r.co = f == 2'd0 ? s > 15 : f == 2'd1 ? s < 0 : 1'b0;
        r.e  = e;
        return r;
    endfunction
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", n, act, exp, $time);
        end
    endtask
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f, input logic c);
        int n = 0;
        bus.req_a = a; bus.req_b = b; bus.req_f = f; bus.req_cci = c; bus.req_valid = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stuck low, required 1");
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask
    task automatic send_rand();
        send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        int n = 0;
        bus.resp_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(q.size()), 0);
    endtask
    task automatic directed(input string n, input logic [3:0] a, input logic [3:0] b, input logic [1:0] f, input logic c, input logic [3:0] xd, input logic xco);
        bus.resp_ready = 1'b0;
        send(a, b, f, c);
        chk({n, "_lat_early"}, 32'(bus.resp_valid), 0);
        step();
        chk({n, "_lat_valid"}, 32'(bus.resp_valid), 1);
        chk({n, "_d"}, 32'(bus.resp_d), 32'(xd));
        chk({n, "_co"}, 32'(bus.resp_co), 32'(xco));
        drain();
    endtask
    initial begin
        int t0, r0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_f = '0; bus.req_cci = 1'b0; bus.resp_ready = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (edges > 0) begin
                    chk("req_ready", 32'(bus.req_ready), 32'(q.size() < FIFO_DEPTH + 1));
                    chk("resp_valid", 32'(bus.resp_valid), 32'(q.size() > 0 && q[0].e < edges));
                    chk("ops_done", 32'(bus.ops_done), 32'(m_done % (1 << CNT_W)));
                    if (bus.resp_valid && bus.resp_ready && q.size() > 0) begin
                        chk("resp_d", 32'(bus.resp_d), 32'(q[0].d));
                        chk("resp_co", 32'(bus.resp_co), 32'(q[0].co));
                    end
                    if (rst) begin
                        q.delete();
                        m_done = 0;
                    end else begin
                        if (bus.resp_valid && bus.resp_ready && q.size() > 0) begin
                            void'(q.pop_front());
                            m_done++;
                            n_resp++;
                        end
                        if (bus.req_valid && bus.req_ready) begin
                            q.push_back(ref_op(bus.req_a, bus.req_b, bus.req_f, bus.req_cci, edges + 1));
                            n_acc++;
                        end
                    end
                end
            end
        join_none
        repeat (3) step();
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_d", 32'(bus.resp_d), 0);
        chk("rst_resp_co", 32'(bus.resp_co), 0);
        chk("rst_ops_done", 32'(bus.ops_done), 0);
        rst = 1'b0;
        step();
        directed("add", 4'h9, 4'h8, 2'b00, 1'b1, 4'h2, 1'b1);
        directed("sub", 4'h3, 4'h5, 2'b01, 1'b0, 4'hE, 1'b1);
        directed("and", 4'hC, 4'hA, 2'b10, 1'b1, 4'h8, 1'b0);
        directed("or", 4'hC, 4'hA, 2'b11, 1'b1, 4'hE, 1'b0);
        // backpressure: three fit (stage 1 + two FIFO entries), the fourth must wait
        bus.resp_ready = 1'b0;
        t0 = n_acc;
        r0 = n_resp;
        repeat (3) send_rand();
        bus.req_a = 4'h7; bus.req_b = 4'h2; bus.req_f = 2'b01; bus.req_cci = 1'b1; bus.req_valid = 1'b1;
        repeat (3) begin
            step();
            chk("bp_req_ready", 32'(bus.req_ready), 0);
            chk("bp_accepted", 32'(n_acc - t0), 3);
        end
        bus.resp_ready = 1'b1;
        send(4'h7, 4'h2, 2'b01, 1'b1);
        chk("bp_resp_before_4th", 32'(n_resp - r0 >= 1), 1);
        drain();
        t0 = edges;
        r0 = n_resp;
        for (int i = 0; i < 16; i++) send_rand();
        chk("stream_cycles", 32'(edges - t0), 16);
        repeat (2) step();
        chk("stream_resps", 32'(n_resp - r0), 16);
        drain();
        bus.resp_ready = 1'b0;
        repeat (2) send_rand();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (5) begin
            step();
            chk("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
            chk("mid_rst_ops_done", 32'(bus.ops_done), 0);
            chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
        end
        for (int i = 0; i < 17; i++) send_rand();
        repeat (2) step();
        chk("wrap_ops_done", 32'(bus.ops_done), 1);
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send_rand();
                    repeat ($urandom_range(0, 2)) step();
                end
                done = 1'b1;
            end
            while (!done) begin
                step();
                bus.resp_ready = $urandom_range(0, 3) != 0;
            end
        join
        drain();
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
